// File: rtl/adc_frame_packetizer.sv
// ---------------------------------------------------------------------------
// adc_frame_packetizer
//
// Turns each valid-strobed ADC sample into a 5-byte frame for the FT2232H
// FIFO interface:  0xA5, seq, sample[15:8], sample[7:0], seq^hi^lo.
// Each byte occupies one slot of BYTE_PERIOD cycles. tx_data_rdy_o is high
// for the first half of the slot, and its rising edge marks a new byte.
// A one-deep buffer holds a sample that arrives mid-frame. Any further
// sample is dropped and counted.
//
// Ports
//   clk_i          system clock
//   reset_ni       synchronous active-low reset
//   sample_i       ADC sample (SAMPLE_W bits, zero-extended to 16)
//   sample_vld_i   single-cycle sample strobe
//   tx_data_rdy_o  byte strobe; rising edge = new byte
//   tx_data_o      byte, stable for the whole slot
//   busy_o         frame in progress
//   overflow_o     one-cycle pulse per dropped sample
//   drop_cnt_o     dropped-sample count, saturating at 255
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no frame; waiting for sample_vld_i
// HDR   | presenting header byte 0xA5
// SEQ   | presenting sequence number
// HI    | presenting sample high byte
// LO    | presenting sample low byte
// CHK   | presenting checksum; last cycle chains or idles
// ---------------------------------------------------------------------------
module adc_frame_packetizer #(
    parameter int BYTE_PERIOD = 8,
    parameter int SAMPLE_W    = 12
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_vld_i,
    output logic                tx_data_rdy_o,
    output logic [7:0]          tx_data_o,
    output logic                busy_o,
    output logic                overflow_o,
    output logic [7:0]          drop_cnt_o
);

    localparam int              CW        = $clog2(BYTE_PERIOD);
    localparam logic [CW-1:0]   SLOT_LAST = CW'(BYTE_PERIOD - 1);
    localparam logic [CW-1:0]   SLOT_HALF = CW'(BYTE_PERIOD / 2);
    localparam logic [7:0]      HDR_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEQ,
        S_HI,
        S_LO,
        S_CHK
    } state_t;

    state_t        state;
    logic [CW-1:0] slot_cnt;
    logic [15:0]   frame_q;
    logic [15:0]   buf_q;
    logic          buf_vld;
    logic [7:0]    seq_q;

    logic [15:0]   sample_ext;
    logic [CW-1:0] slot_next;
    logic          slot_end;
    logic          frame_end;

    assign sample_ext = 16'(sample_i);
    assign slot_next  = slot_cnt + CW'(1);
    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign frame_end  = (state == S_CHK) && slot_end;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state         <= S_IDLE;
            slot_cnt      <= '0;
            frame_q       <= '0;
            buf_q         <= '0;
            buf_vld       <= 1'b0;
            seq_q         <= '0;
            tx_data_rdy_o <= 1'b0;
            tx_data_o     <= '0;
            busy_o        <= 1'b0;
            overflow_o    <= 1'b0;
            drop_cnt_o    <= '0;
        end else begin
            overflow_o <= 1'b0;

            if (state == S_IDLE) begin
                slot_cnt      <= '0;
                tx_data_rdy_o <= 1'b0;
                busy_o        <= 1'b0;
                if (sample_vld_i) begin
                    frame_q       <= sample_ext;
                    state         <= S_HDR;
                    tx_data_rdy_o <= 1'b1;
                    tx_data_o     <= HDR_BYTE;
                    busy_o        <= 1'b1;
                end
            end else begin
                if (slot_end) begin
                    // Slot boundary: next byte goes out together with the strobe edge.
                    slot_cnt      <= '0;
                    tx_data_rdy_o <= 1'b1;
                    case (state)
                        S_HDR: begin
                            state     <= S_SEQ;
                            tx_data_o <= seq_q;
                        end
                        S_SEQ: begin
                            state     <= S_HI;
                            tx_data_o <= frame_q[15:8];
                        end
                        S_HI: begin
                            state     <= S_LO;
                            tx_data_o <= frame_q[7:0];
                        end
                        S_LO: begin
                            state     <= S_CHK;
                            tx_data_o <= seq_q ^ frame_q[15:8] ^ frame_q[7:0];
                        end
                        default: begin
                            seq_q <= seq_q + 8'd1;
                            if (buf_vld) begin
                                // Buffered sample becomes the next frame; a strobe
                                // landing now refills the freed buffer.
                                frame_q   <= buf_q;
                                buf_vld   <= sample_vld_i;
                                if (sample_vld_i) begin
                                    buf_q <= sample_ext;
                                end
                                state     <= S_HDR;
                                tx_data_o <= HDR_BYTE;
                            end else if (sample_vld_i) begin
                                frame_q   <= sample_ext;
                                state     <= S_HDR;
                                tx_data_o <= HDR_BYTE;
                            end else begin
                                state         <= S_IDLE;
                                tx_data_rdy_o <= 1'b0;
                                busy_o        <= 1'b0;
                            end
                        end
                    endcase
                end else begin
                    slot_cnt      <= slot_next;
                    tx_data_rdy_o <= (slot_next < SLOT_HALF);
                end

                // Mid-frame arrivals; the last CHK cycle is handled above.
                if (sample_vld_i && !frame_end) begin
                    if (!buf_vld) begin
                        buf_q   <= sample_ext;
                        buf_vld <= 1'b1;
                    end else begin
                        overflow_o <= 1'b1;
                        if (drop_cnt_o != 8'hFF) begin
                            drop_cnt_o <= drop_cnt_o + 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_packetizer.sv
// ---------------------------------------------------------------------------
// tb_adc_frame_packetizer
//
// Scoreboard bench. The stimulus side predicts each frame from the
// frame-scheduling rules: each accepted sample occupies a 5*BP interval that
// either starts the cycle after the strobe or chains onto the previous frame.
// It pushes the expected (cycle, byte) pairs, the busy intervals and the
// overflow cycles into queues. The monitor checks the DUT against those
// queues on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_adc_frame_packetizer;

    localparam int BP    = 8;
    localparam int SW    = 12;
    localparam int FRAME = 5 * BP;

    logic          clk        = 1'b0;
    logic          reset_ni   = 1'b0;
    logic [SW-1:0] sample     = '0;
    logic          sample_vld = 1'b0;
    logic          tx_data_rdy;
    logic [7:0]    tx_data;
    logic          busy;
    logic          overflow;
    logic [7:0]    drop_cnt;

    adc_frame_packetizer #(
        .BYTE_PERIOD (BP),
        .SAMPLE_W    (SW)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .sample_i      (sample),
        .sample_vld_i  (sample_vld),
        .tx_data_rdy_o (tx_data_rdy),
        .tx_data_o     (tx_data),
        .busy_o        (busy),
        .overflow_o    (overflow),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int exp_cyc[$];
    int exp_byte[$];
    int iv_s[$];
    int iv_e[$];
    int ovf_q[$];

    int tail_start = -1000;
    int tail_end   = -1000;
    int seq_m      = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Strobe seen in cycle n. It is accepted if the DUT is idle, if a frame is
    // running with no sample waiting, or if this is the last cycle of the
    // running frame (the waiting sample is just leaving). Otherwise it is dropped.
    task automatic model_strobe(input int n, input int s);
        int st;
        int hi;
        int lo;
        hi = (s >> 8) & 255;
        lo = s & 255;
        if (tail_end < n) begin
            st = n + 1;
        end else if (tail_start <= n || tail_start == n + 1) begin
            st = tail_end + 1;
        end else begin
            ovf_q.push_back(n + 1);
            return;
        end
        tail_start = st;
        tail_end   = st + FRAME - 1;
        iv_s.push_back(tail_start);
        iv_e.push_back(tail_end);
        exp_cyc.push_back(st);          exp_byte.push_back(8'hA5);
        exp_cyc.push_back(st + BP);     exp_byte.push_back(seq_m);
        exp_cyc.push_back(st + 2 * BP); exp_byte.push_back(hi);
        exp_cyc.push_back(st + 3 * BP); exp_byte.push_back(lo);
        exp_cyc.push_back(st + 4 * BP); exp_byte.push_back(seq_m ^ hi ^ lo);
        seq_m = (seq_m + 1) % 256;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic strobe(input int s);
        sample     = SW'(s);
        sample_vld = 1'b1;
        model_strobe(cyc, s);
        tick();
        sample_vld = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic rst_q     = 1'b0;
    logic prev_rdy  = 1'b0;
    int   hcnt      = 0;
    int   last_byte = 0;
    int   ovf_seen  = 0;

    always @(posedge clk) rst_q <= reset_ni;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_q) begin
                chk("rst_rdy",  int'(tx_data_rdy), 0);
                chk("rst_data", int'(tx_data),     0);
                chk("rst_busy", int'(busy),        0);
                chk("rst_ovf",  int'(overflow),    0);
                chk("rst_drop", int'(drop_cnt),    0);
                prev_rdy  = 1'b0;
                hcnt      = 0;
                last_byte = 0;
                ovf_seen  = 0;
            end else begin
                while (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
                    chk("byte_missed", cyc, exp_cyc[0]);
                    void'(exp_cyc.pop_front());
                    void'(exp_byte.pop_front());
                end
                if (tx_data_rdy && !prev_rdy) begin
                    chk("byte_expected", int'(exp_byte.size() > 0), 1);
                    if (exp_byte.size() > 0) begin
                        chk("byte_cycle", cyc, exp_cyc.pop_front());
                        chk("byte_value", int'(tx_data), exp_byte.pop_front());
                    end
                    hcnt = 1;
                end else begin
                    chk("data_stable", int'(tx_data), last_byte);
                    if (tx_data_rdy) hcnt++;
                end
                if (!tx_data_rdy && prev_rdy) begin
                    chk("rdy_high_len", hcnt, BP / 2);
                end

                while (iv_e.size() > 0 && iv_e[0] < cyc) begin
                    void'(iv_s.pop_front());
                    void'(iv_e.pop_front());
                end
                chk("busy", int'(busy), int'(iv_s.size() > 0 && iv_s[0] <= cyc));

                while (ovf_q.size() > 0 && ovf_q[0] < cyc) begin
                    chk("ovf_missed", cyc, ovf_q.pop_front());
                end
                if (overflow) begin
                    chk("ovf_expected", int'(ovf_q.size() > 0), 1);
                    if (ovf_q.size() > 0) begin
                        chk("ovf_cycle", cyc, ovf_q.pop_front());
                    end
                    ovf_seen++;
                    chk("drop_cnt", int'(drop_cnt), (ovf_seen > 255) ? 255 : ovf_seen);
                end
                prev_rdy  = tx_data_rdy;
                last_byte = int'(tx_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_ni = 1'b0;
        idle(3);
        reset_ni = 1'b1;
        idle(5);

        // single sample: A5 00 0A BC B6
        strobe(12'hABC);
        idle(FRAME + 10);

        // three samples inside one frame: second chains, third drops
        strobe(12'h001); idle(2);
        strobe(12'h002); idle(2);
        strobe(12'h003);
        idle(2 * FRAME + 10);

        // strobe on the final CHK cycle with the buffer empty
        strobe(12'h100);
        idle(FRAME - 1);
        strobe(12'h155);
        idle(FRAME + 10);

        // randomised spacing, long enough to wrap the sequence number
        for (int i = 0; i < 300; i++) begin
            strobe(int'($urandom_range(0, 4095)));
            if ((i % 8) == 7) idle(int'($urandom_range(0, 3)));
            else              idle(int'($urandom_range(FRAME - 4, FRAME + 6)));
        end
        idle(3 * FRAME);

        // continuous strobes: drop counter saturates
        repeat (5000) strobe(int'($urandom_range(0, 4095)));
        idle(3 * FRAME);

        // reset during HI slot with a sample buffered
        strobe(12'h222);
        idle(1);
        strobe(12'h333);
        idle(2 * BP);
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        exp_cyc.delete();
        exp_byte.delete();
        iv_s.delete();
        iv_e.delete();
        ovf_q.delete();
        tail_start = -1000;
        tail_end   = -1000;
        seq_m      = 0;
        idle(2 * FRAME);
        strobe(12'h444);
        idle(3 * FRAME);

        chk("bytes_left", int'(exp_byte.size()), 0);
        chk("ovf_left",   int'(ovf_q.size()),    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_frame_packetizer.md
# adc_frame_packetizer

Upstream feeder for the FT2232H FIFO interface. Takes ADC samples (valid-strobed) and turns each one into a 5-byte frame: header, sequence number, sample high byte, sample low byte, checksum. Bytes are presented one per byte slot, with a rising-edge data-ready strobe spaced so the downstream FIFO interface always completes its TX/RX cycle before the next edge. A one-deep holding buffer absorbs a sample arriving mid-frame; further samples are dropped and counted.

## Interface
- BYTE_PERIOD, 8, clock cycles per byte slot; legal range ≥ 6 (downstream needs 5 cycles from edge back to idle, plus ≥ 1 low cycle).
- SAMPLE_W, 12, sample width; legal range 1..16, zero-extended to 16 bits.
- clk_i  input  1  system clock.
- reset_ni  input  1  reset; one clock, synchronous, active-low.
- sample_i  input  SAMPLE_W  ADC sample; sampled only when sample_vld_i = 1.
- sample_vld_i  input  1  single-cycle sample strobe.
- tx_data_rdy_o  output  1  byte strobe to FIFO interface; its rising edge marks a new byte.
- tx_data_o  output  8  byte to FIFO interface; stable for the whole slot.
- busy_o  output  1  frame in progress (state ≠ IDLE).
- overflow_o  output  1  one-cycle pulse when a sample is dropped.
- drop_cnt_o  output  8  dropped-sample count; saturates at 255.

## Operation
- Frame byte order: 0xA5, seq[7:0], s16[15:8], s16[7:0], chk.
  - s16 is the zero-extended sample.
  - chk = seq ^ s16[15:8] ^ s16[7:0].
- States: IDLE, HDR, SEQ, HI, LO, CHK.
  - Each non-IDLE state lasts exactly BYTE_PERIOD cycles, timed by a slot counter running 0..BYTE_PERIOD-1.
  - Transitions: HDR→SEQ→HI→LO→CHK.
- IDLE with sample_vld_i: latch the sample into the frame register; go to HDR next cycle.
- Sample arriving during a frame:
  - Buffer empty: store it in the buffer.
  - Buffer full: drop it, pulse overflow_o, increment drop_cnt_o (saturating at 255).
- Last cycle of CHK:
  - Buffer valid: the buffer becomes the next frame and the next state is HDR, with no idle gap. A sample arriving in that same cycle refills the buffer (no drop).
  - Buffer empty and sample_vld_i = 1: that sample starts the next frame directly (HDR).
  - Otherwise: go to IDLE.
- seq increments by 1 at the end of every transmitted frame and wraps 255→0. Dropped samples do not consume a sequence number.
- No backpressure from the FIFO interface. Its error flags are not monitored here.

## Timing
- All outputs are registered.
- Reset values: tx_data_rdy_o = 0, tx_data_o = 0x00, busy_o = 0, overflow_o = 0, drop_cnt_o = 0. Internally, seq = 0 and the buffer is empty.
- Latency: sample_vld_i in IDLE at cycle T → tx_data_rdy_o = 1 and tx_data_o = 0xA5 at T+1.
- Within each slot:
  - tx_data_rdy_o is high for slot counts 0..(BYTE_PERIOD/2 − 1) and low for the remainder.
  - tx_data_o changes only at slot count 0, in the same cycle tx_data_rdy_o rises.
- Rising edges are exactly BYTE_PERIOD cycles apart within a frame and across back-to-back frames.
- A frame occupies 5·BYTE_PERIOD cycles. Sustained throughput without drops is one sample per 5·BYTE_PERIOD cycles.
- busy_o is high from T+1 through the last CHK cycle.
- overflow_o pulses in the cycle after the dropped strobe.
- Reset mid-frame aborts the frame. The next cycle shows reset values, and the buffered sample is discarded.

## Test plan
- Single sample: sample 0xABC, BYTE_PERIOD = 8, after reset → bytes A5, 00, 0A, BC, B6.
  - tx_data_rdy_o high for 4 cycles, with rising edges 8 cycles apart.
  - busy_o high for 40 cycles, then IDLE.
- Back-to-back: three samples (0x001, 0x002, 0x003) during one frame.
  - Second frame follows with no gap: A5, 01, 00, 02, 03.
  - Third sample dropped: overflow_o pulses once and drop_cnt_o = 1.
- Last-cycle boundary: buffer empty, strobe 0x155 on the final CHK cycle → next cycle starts HDR with seq 01 and bytes 01, 55. No drop.
- Sequence wrap: 257 spaced samples → frame 256 carries seq FF and frame 257 carries seq 00.
- Drop saturation: continuous strobes every cycle for 5000 cycles → drop_cnt_o stops at 255. overflow_o keeps pulsing on each drop.
- Reset mid-frame: reset_ni low during the HI slot with a sample buffered → next cycle all outputs are at reset values. A later sample produces seq 00 and no buffered frame is emitted.
